fft_frame_sequencer: RTL and testbench

Sequences one FFT frame at a time through the FFT core. It loads FRAME_LEN samples from the sample RAM into the core, then waits for the core's transform output. Each result is written into the result RAM at its output index. It sits between the capture buffer (which raises frame_req when a frame is stored) and the FFT core/result RAM, and reports completion, busy and error status to the system controller.

---
 rtl/fft_frame_sequencer.sv | 117 +++++++++++
 tb/tb_fft_frame_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer.sv
// Moves one frame of samples from the sample RAM into the FFT core, then
// writes each core output word into the result RAM at its output index.
module fft_frame_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 256,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_req,
  output logic              frame_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              fft_start,
  input  logic              fft_rfd,
  output logic [DATA_W-1:0] fft_din,
  output logic              fft_din_valid,
  input  logic              fft_dv,
  input  logic [DATA_W-1:0] fft_dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_spurious,
  output logic [15:0]       frame_count
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_WAIT_OUT = 3'd3;
  localparam logic [2:0] S_UNLOAD   = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // Indices carry one extra bit so a frame of exactly 2^ADDR_W words terminates.
  localparam int IW = ADDR_W + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] LEN    = IW'(FRAME_LEN);
  localparam logic [IW-1:0] LAST   = IW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state;
  logic [2:0]    next_state;
  logic [IW-1:0] in_idx;
  logic [IW-1:0] out_idx;
  logic [TW-1:0] timer;
  logic          last_wr;
  logic          dv_unexpected;

  always_comb begin
    rd_en         = (state == S_LOAD) && fft_rfd && (in_idx < LEN);
    rd_addr       = rd_en ? in_idx[ADDR_W-1:0] : '0;
    wr_en         = ((state == S_WAIT_OUT) || (state == S_UNLOAD)) && fft_dv;
    wr_addr       = wr_en ? out_idx[ADDR_W-1:0] : '0;
    wr_data       = wr_en ? fft_dout : '0;
    fft_din       = fft_din_valid ? rd_data : '0;
    last_wr       = wr_en && (out_idx == LAST);
    dv_unexpected = fft_dv && ((state == S_IDLE) || (state == S_START) || (state == S_LOAD));
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (frame_req) next_state = S_START;
      S_START:    next_state = S_LOAD;
      // Leave only once the in-flight word of the final read has been presented.
      S_LOAD:     if (in_idx == LEN) next_state = S_WAIT_OUT;
      S_WAIT_OUT: begin
        if (fft_dv)               next_state = last_wr ? S_DONE : S_UNLOAD;
        else if (timer == T_LAST) next_state = S_IDLE;
      end
      S_UNLOAD:   if (last_wr) next_state = S_DONE;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      in_idx        <= '0;
      out_idx       <= '0;
      timer         <= '0;
      frame_ack     <= 1'b0;
      fft_start     <= 1'b0;
      fft_din_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      err_spurious  <= 1'b0;
      frame_count   <= '0;
    end else begin
      state         <= next_state;
      frame_ack     <= (next_state == S_START);
      fft_start     <= (next_state == S_START);
      busy          <= (next_state != S_IDLE);
      done          <= (next_state == S_DONE);
      fft_din_valid <= rd_en;
      if (next_state == S_DONE) frame_count <= frame_count + 16'd1;
      if (state == S_START) begin
        in_idx  <= '0;
        out_idx <= '0;
        timer   <= '0;
      end
      if (rd_en) in_idx <= in_idx + 1'b1;
      if (wr_en) out_idx <= out_idx + 1'b1;
      if (state == S_WAIT_OUT) timer <= timer + 1'b1;
      if ((state == S_WAIT_OUT) && !fft_dv && (timer == T_LAST)) err_timeout <= 1'b1;
      if (dv_unexpected) err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench: sample-RAM and FFT-core models, random data, rfd and dv gaps;
// a monitor compares every read and result write against queued expectations.
`timescale 1ns/1ps
module tb_fft_frame_sequencer;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 256;
  localparam int TIMEOUT   = 4096;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_req = 1'b0;
  logic              frame_ack;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              fft_start;
  logic              fft_rfd = 1'b1;
  logic [DATA_W-1:0] fft_din;
  logic              fft_din_valid;
  logic              fft_dv = 1'b0;
  logic [DATA_W-1:0] fft_dout = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err_timeout;
  logic              err_spurious;
  logic [15:0]       frame_count;

  fft_frame_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .frame_req(frame_req), .frame_ack(frame_ack),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .fft_start(fft_start),
    .fft_rfd(fft_rfd), .fft_din(fft_din), .fft_din_valid(fft_din_valid),
    .fft_dv(fft_dv), .fft_dout(fft_dout), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .err_timeout(err_timeout),
    .err_spurious(err_spurious), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] sample_mem [FRAME_LEN];
  wr_t               exp_wr[$];
  logic [DATA_W-1:0] core_in[$];
  logic [DATA_W-1:0] out_q[$];

  int rfd_mode = 0;
  int gap_pct = 0;
  int core_lat = 10;
  bit core_silent = 1'b0;
  bit force_dv = 1'b0;
  int exp_frames = 0;

  int rd_exp = 0;
  int unsigned last_rd_cyc = 0;
  int ack_cnt = 0;
  int done_cnt = 0;

  logic any_out;
  assign any_out = |{frame_ack, rd_en, rd_addr, fft_start, fft_din, fft_din_valid, wr_en,
                     wr_addr, wr_data, busy, done, err_timeout, err_spurious, frame_count};

  function automatic logic [DATA_W-1:0] core_xform(input logic [DATA_W-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Fill the sample RAM with a fresh frame; the result RAM must end up holding
  // the core's transform of each sample at the sample's own index.
  task automatic applyStimulus(input bit expect_result);
    wr_t e;
    for (int i = 0; i < FRAME_LEN; i++) begin
      sample_mem[i] = $urandom;
      if (expect_result) begin
        e.addr = ADDR_W'(i);
        e.data = core_xform(sample_mem[i]);
        exp_wr.push_back(e);
      end
    end
  endtask

  task automatic waitAck(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_ack) begin
        at_cyc = int'(cyc);
        break;
      end
    end
    if (at_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL frame_ack_wait: got no pulse, expected one within %0d cycles", budget);
    end
  endtask

  task automatic waitDone(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at_cyc = int'(cyc);
        break;
      end
    end
    if (at_cyc < 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL done_wait: got no pulse, expected one within %0d cycles", budget);
    end
  endtask

  task automatic checkIdleAfterFrame();
    @(negedge clk);
    checkOutput("busy_after_done", busy, 0);
    checkOutput("frame_count", frame_count, exp_frames);
    checkOutput("results_outstanding", exp_wr.size(), 0);
  endtask

  task automatic runFrame();
    int a, d;
    applyStimulus(1'b1);
    @(posedge clk); #1 frame_req = 1'b1;
    waitAck(20, a);
    @(posedge clk); #1 frame_req = 1'b0;
    waitDone(4000, d);
    exp_frames++;
    checkIdleAfterFrame();
  endtask

  // Sample RAM: one-cycle read latency.
  initial begin : sample_ram
    logic              pend;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      pend = rd_en;
      a = rd_addr;
      @(posedge clk); #1;
      if (pend) rd_data = sample_mem[a];
    end
  end

  initial begin : rfd_driver
    forever begin
      @(posedge clk); #1;
      case (rfd_mode)
        0:       fft_rfd = 1'b1;
        1:       fft_rfd = ~fft_rfd;
        default: fft_rfd = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // FFT core: collects a full frame, then streams the transformed words in order.
  initial begin : core_model
    int countdown;
    countdown = 0;
    forever begin
      @(negedge clk);
      if (!rst && fft_din_valid) core_in.push_back(fft_din);
      @(posedge clk); #1;
      fft_dv = 1'b0;
      fft_dout = '0;
      if (rst) begin
        core_in.delete();
        out_q.delete();
        continue;
      end
      if (core_in.size() == FRAME_LEN) begin
        if (!core_silent) foreach (core_in[i]) out_q.push_back(core_xform(core_in[i]));
        countdown = core_lat;
        core_in.delete();
      end
      if (force_dv) begin
        fft_dv = 1'b1;
        fft_dout = $urandom;
        force_dv = 1'b0;
      end else if (out_q.size() > 0) begin
        if (countdown > 0) countdown--;
        else if ($urandom_range(0, 99) >= gap_pct) begin
          fft_dv = 1'b1;
          fft_dout = out_q.pop_front();
        end
      end
    end
  end

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_ack) begin
          ack_cnt++;
          rd_exp = 0;
        end
        if (rd_en) begin
          checkOutput("rd_addr_order", rd_addr, rd_exp);
          checkOutput("rd_while_rfd_low", fft_rfd, 1);
          if (rd_addr == ADDR_W'(FRAME_LEN - 1)) last_rd_cyc = cyc;
          rd_exp++;
        end
        if (wr_en) begin
          if (exp_wr.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL unexpected_write: got wr_addr %0h data %0h, expected no write", wr_addr, wr_data);
          end else begin
            e = exp_wr.pop_front();
            checkOutput("wr_addr", wr_addr, e.addr);
            checkOutput("wr_data", wr_data, e.data);
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int a, d, prev_done, prev_ack, t_rise;
    int unsigned d_cyc;
    bit hit;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", any_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_outputs", any_out, 0);

    $display("[TB] plain frame, rfd held high");
    rfd_mode = 0; gap_pct = 0; core_lat = 10;
    runFrame();

    $display("[TB] frame with rfd toggling");
    rfd_mode = 1;
    runFrame();

    $display("[TB] random rfd, latency and dv gaps");
    for (int k = 0; k < 3; k++) begin
      rfd_mode = 2;
      gap_pct = $urandom_range(0, 40);
      core_lat = $urandom_range(0, 12);
      runFrame();
    end
    checkOutput("no_spurious_yet", err_spurious, 0);
    checkOutput("no_timeout_yet", err_timeout, 0);

    $display("[TB] dv pulse while idle");
    force_dv = 1'b1;
    @(negedge clk);
    checkOutput("spurious_wr_en", wr_en, 0);
    @(negedge clk);
    checkOutput("err_spurious", err_spurious, 1);
    checkOutput("spurious_busy", busy, 0);
    rfd_mode = 0; gap_pct = 10; core_lat = 5;
    runFrame();

    $display("[TB] three back-to-back frames");
    prev_done = done_cnt;
    prev_ack = ack_cnt;
    rfd_mode = 2; gap_pct = 20;
    applyStimulus(1'b1);
    @(posedge clk); #1 frame_req = 1'b1;
    waitAck(20, a);
    for (int k = 0; k < 3; k++) begin
      waitDone(4000, d);
      exp_frames++;
      if (k < 2) begin
        d_cyc = cyc;
        applyStimulus(1'b1);
        waitAck(10, a);
        checkOutput("done_to_start_gap", a - int'(d_cyc), 2);
      end
    end
    @(posedge clk); #1 frame_req = 1'b0;
    checkIdleAfterFrame();
    checkOutput("b2b_done_pulses", done_cnt - prev_done, 3);
    checkOutput("b2b_ack_pulses", ack_cnt - prev_ack, 3);

    $display("[TB] core never responds");
    prev_done = done_cnt;
    rfd_mode = 0; gap_pct = 0; core_silent = 1'b1;
    applyStimulus(1'b0);
    @(posedge clk); #1 frame_req = 1'b1;
    waitAck(20, a);
    @(posedge clk); #1 frame_req = 1'b0;
    t_rise = -1;
    for (int i = 0; i < TIMEOUT + 1000; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        t_rise = int'(cyc);
        break;
      end
    end
    checkOutput("timeout_latency", t_rise - int'(last_rd_cyc), TIMEOUT + 2);
    checkOutput("timeout_busy", busy, 0);
    checkOutput("timeout_no_done", done_cnt - prev_done, 0);
    checkOutput("timeout_frame_count", frame_count, exp_frames);
    core_silent = 1'b0;

    $display("[TB] reset in the middle of loading");
    rfd_mode = 2;
    applyStimulus(1'b0);
    @(posedge clk); #1 frame_req = 1'b1;
    waitAck(20, a);
    hit = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == ADDR_W'(100)) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("reached_index_100", hit, 1);
    #1 rst = 1'b1;
    #1 checkOutput("async_reset_outputs", any_out, 0);
    exp_wr.delete();
    exp_frames = 0;
    applyStimulus(1'b1);
    rfd_mode = 0; gap_pct = 15; core_lat = 3;
    repeat (3) @(negedge clk);
    checkOutput("held_reset_outputs", any_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    waitAck(20, a);
    @(posedge clk); #1 frame_req = 1'b0;
    waitDone(4000, d);
    exp_frames++;
    checkIdleAfterFrame();
    checkOutput("errors_cleared_timeout", err_timeout, 0);
    checkOutput("errors_cleared_spurious", err_spurious, 0);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
